seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Multi-cycle shift-add multiplier, parametrised successor to the combinational
//   multiplier. Trades latency for area: one partial product per clock. Sits in the
//   ALU datapath behind a start/done handshake. Full-width product plus overflow flag.
// PARAMETERS
//   SIZE     4   operand width in bits (>=2); product width is 2*SIZE
// PORTS
//   clk    in   1        clock; all state changes on rising edge
//   rst    in   1        synchronous reset, active-high
//   start  in   1        request; sampled only in IDLE
//   a      in   SIZE     multiplicand, captured on accepted start
//   b      in   SIZE     multiplier, captured on accepted start
//   busy   out  1        high in CALC and DONE; start ignored while high
//   done   out  1        one-cycle pulse: c/over valid
//   over   out  1        product does not fit in SIZE bits
//   c      out  2*SIZE   product; held from done until next accepted start
// BEHAVIOUR
//   - Reset (sync, rst=1 at edge): state=IDLE, busy=0, done=0, over=0, c=0,
//     internal accumulator/counter cleared. Wins over every other input.
//   - FSM: IDLE -(start)-> CALC -(count==SIZE-1)-> DONE -(always)-> IDLE.
//   - Edge N, IDLE, start=1: latch a,b; acc=0; count=0; go CALC. start=0: stay.
//   - CALC, edges N+1..N+SIZE: if b_reg[0] acc += a_reg<<count (2*SIZE wide, no
//     truncation); b_reg >>= 1; count++. Exactly SIZE iterations, no early exit
//     (zero operands take the same latency).
//   - Edge N+SIZE: final iteration; c and over registered; go DONE.
//   - DONE: done=1 for exactly one cycle (between edges N+SIZE and N+SIZE+1);
//     busy=1; next edge -> IDLE. Latency start-edge to done = SIZE edges;
//     back-to-back throughput one result per SIZE+2 cycles.
//   - start high in CALC/DONE: ignored, not queued. a/b changes after capture:
//     no effect on the running product.
//   - start held high continuously: new op accepted on first IDLE cycle.
//   - rst mid-CALC: operation abandoned, no done pulse, outputs to reset values.
//   - over (unsigned): over = |c[2*SIZE-1:SIZE]. Updated only with c.
//   - c, over stable outside DONE; unchanged by ignored starts.
// CONFIGURATION
//   SEQ_MULTIPLIER_SIGNED_EN
//   - Undefined: a, b, c unsigned; over as above.
//   - Defined: a, b two's complement. Operands converted to magnitudes at capture,
//     unsigned shift-add as above, result negated at final edge if signs differ.
//     c = signed 2*SIZE product; over=1 when c outside [-2^(SIZE-1), 2^(SIZE-1)-1].
//     Latency, handshake and FSM identical. Most-negative operand handled exactly
//     (e.g. SIZE=4: -8 * -8 = +64, c=8'b01000000, over=1).
// TESTING
//   All cases SIZE=4 unless noted; check done pulse exactly 4 edges after start edge.
//   1 Unsigned sweep: a=1111 with b=0000,0001,0010,0011,0100,1001 -> c=00000000,
//     00001111,00011110,00101101,00111100,10000111; over=0,0,1,1,1,1.
//   2 Handshake: start pulse then start held high during CALC with new a/b -> no
//     restart, single done, c from first operands; busy low again edge N+6.
//   3 Reset mid-op: rst at edge N+2 of a=1111,b=1111 -> no done, c=0, over=0,
//     busy=0; next start a=0011,b=0101 -> c=00001111.
//   4 Back-to-back, start tied high: 3*5 then 7*7 -> done pulses 6 cycles apart,
//     c=00001111 then 00110001.
//   5 SIGNED_EN: a=1111(-1),b=0011(3) -> c=11111101, over=0; a=1000,b=1000 ->
//     c=01000000, over=1; a=0111,b=1001(-7) -> c=11001111, over=1.
//   6 SIZE=8 unsigned: a=0xFF,b=0xFF -> c=16'hFE01, over=1, done 8 edges after start.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per clock; SEQ_MULTIPLIER_SIGNED_EN selects two's complement operands
module seq_multiplier #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic              over,
  output logic [2*SIZE-1:0] c
);
  localparam int W = 2 * SIZE;
  localparam int CW = $clog2(SIZE);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [W-1:0] a_reg, acc, sum, prod;
  logic [SIZE-1:0] b_reg, am, bm;
  logic [CW-1:0] cnt;
  logic neg, sn, ovf;
  // operand magnitudes at capture, running sum and final product with overflow
  always_comb begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    am = a[SIZE-1] ? -a : a;
    bm = b[SIZE-1] ? -b : b;
    sn = a[SIZE-1] ^ b[SIZE-1];
`else
    am = a;
    bm = b;
    sn = 1'b0;
`endif
    sum = acc + (b_reg[0] ? a_reg : '0);
    prod = neg ? -sum : sum;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    ovf = ~(&prod[W-1:SIZE-1] | ~|prod[W-1:SIZE-1]);
`else
    ovf = |prod[W-1:SIZE];
`endif
  end
  // control FSM: capture in IDLE, SIZE shift-add steps in CALC, one-cycle result pulse in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      over <= 1'b0;
      c <= '0;
      acc <= '0;
      cnt <= '0;
      a_reg <= '0;
      b_reg <= '0;
      neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= W'(am);
          b_reg <= bm;
          neg <= sn;
          acc <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          acc <= sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SIZE - 1)) begin
            c <= prod;
            over <= ovf;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of the shift-add multiplier at SIZE=4 and SIZE=8
module tb_seq_multiplier;
  logic clk = 0, rst = 1, start = 0, start8 = 0;
  logic [3:0] a = 0, b = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy, done, over, busy8, done8, over8;
  logic [7:0] c;
  logic [15:0] c8;
  int checks = 0, fails = 0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
  localparam logic OV15 = 1'b1;
  localparam logic [15:0] C8FF = 16'h0001;
  localparam logic OV8FF = 1'b0;
`else
  localparam logic OV15 = 1'b0;
  localparam logic [15:0] C8FF = 16'hFE01;
  localparam logic OV8FF = 1'b1;
`endif

  seq_multiplier #(.SIZE(4)) dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .over(over), .c(c));
  seq_multiplier #(.SIZE(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .over(over8), .c(c8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic [3:0] x, input logic [3:0] y,
                    input logic [7:0] ec, input logic eo);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, 4);
    check({tag, " c"}, c, ec);
    check({tag, " over"}, over, eo);
    @(posedge clk); #1;
    check({tag, " done drop"}, done, 0);
    check({tag, " busy drop"}, busy, 0);
    check({tag, " c held"}, c, ec);
  endtask

  initial begin
    int n, pulses, e1, e2;
    logic [7:0] c1, c2;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst over", over, 0);
    check("rst c", c, 0);
    check("rst c8", c8, 0);
    rst = 0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    op("s -1*3", 4'b1111, 4'b0011, 8'b11111101, 0);
    op("s -8*-8", 4'b1000, 4'b1000, 8'b01000000, 1);
    op("s 7*-7", 4'b0111, 4'b1001, 8'b11001111, 1);
`else
    op("u F*0", 4'hF, 4'h0, 8'h00, 0);
    op("u F*1", 4'hF, 4'h1, 8'h0F, 0);
    op("u F*2", 4'hF, 4'h2, 8'h1E, 1);
    op("u F*3", 4'hF, 4'h3, 8'h2D, 1);
    op("u F*4", 4'hF, 4'h4, 8'h3C, 1);
    op("u F*9", 4'hF, 4'h9, 8'h87, 1);
`endif
    // handshake: start held during CALC/DONE with new operands must be ignored
    @(negedge clk); a = 3; b = 5; start = 1;
    @(posedge clk); #1 a = 7; b = 7;
    pulses = 0; c1 = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; c1 = c; end
      if (i == 5) start = 0;
    end
    check("hs pulses", pulses, 1);
    check("hs c", c1, 8'h0F);
    check("hs busy N+5", busy, 0);
    @(posedge clk); #1;
    check("hs busy N+6", busy, 0);
    check("hs c stable", c, 8'h0F);
    // reset mid-operation
    @(negedge clk); a = 4'hF; b = 4'hF; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    check("rm busy", busy, 0);
    check("rm c", c, 0);
    check("rm over", over, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("rm no done", pulses, 0);
    op("rm next", 4'b0011, 4'b0101, 8'h0F, OV15);
    // back-to-back with start tied high
    @(negedge clk); a = 3; b = 5; start = 1;
    @(posedge clk); #1 a = 7; b = 7;
    e1 = -1; e2 = -1; c1 = 0; c2 = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (done && e1 < 0) begin e1 = i; c1 = c; end
      else if (done && e2 < 0) begin e2 = i; c2 = c; end
    end
    start = 0;
    check("b2b first edge", e1, 4);
    check("b2b spacing", e2 - e1, 6);
    check("b2b c1", c1, 8'h0F);
    check("b2b c2", c2, 8'h31);
    check("b2b over2", over, 1);
    // SIZE=8
    @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; start8 = 1;
    @(posedge clk); #1 start8 = 0;
    n = 0;
    while (!done8 && n < 30) begin @(posedge clk); #1; n++; end
    check("w8 latency", n, 8);
    check("w8 c", c8, C8FF);
    check("w8 over", over8, OV8FF);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
